// File: rtl/fixed_mem_reader.sv
// Read sequencer for the asynchronous fixed-memory ROM.
// One accepted request drives CE_/OE_/A for a programmable access window,
// captures DQ, and returns the word with a one-cycle DONE and a parity flag.
module fixed_mem_reader #(
   parameter int ACCESS_CYCLES = 5
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        REQ,
   input  logic [16:0] ADDR,
   output logic        BUSY,
   output logic        DONE,
   output logic [15:0] DATA,
   output logic        PAR_ERR,
   output logic        CE_,
   output logic        OE_,
   output logic        WE_,
   output logic [16:0] A,
   input  logic [15:0] DQ
);

   localparam int CW = $clog2(ACCESS_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ACCESS  = 2'd2,
      RECOVER = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [16:0]   addr_q, addr_d;
   logic [15:0]   data_q, data_d;
   logic          par_q, par_d;

   // Words are expected to carry odd parity; an even count of ones is an error.
   function automatic logic parity_error(input logic [15:0] word);
      return ~^word;
   endfunction

   // State and datapath registers; reset also clears the captured word.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         par_q   <= par_d;
      end
   end

   // Next-state logic: the counter holds at its last value, so it never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      par_d   = par_q;
      case (state_q)
         IDLE: begin
            if (REQ) begin
               addr_d  = ADDR;
               state_d = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (cnt_q == CNT_LAST) begin
               data_d  = DQ;
               par_d   = parity_error(DQ);
               state_d = RECOVER;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RECOVER: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Pin decode: CE_ covers SETUP+ACCESS, OE_ only ACCESS; DONE is the RECOVER cycle.
   always_comb begin
      CE_  = 1'b1;
      OE_  = 1'b1;
      BUSY = 1'b1;
      DONE = 1'b0;
      case (state_q)
         IDLE:    BUSY = 1'b0;
         SETUP:   CE_  = 1'b0;
         ACCESS: begin
            CE_ = 1'b0;
            OE_ = 1'b0;
         end
         RECOVER: DONE = 1'b1;
         default: BUSY = 1'b0;
      endcase
   end

   assign WE_     = 1'b1;
   assign A       = addr_q;
   assign DATA    = data_q;
   assign PAR_ERR = par_q;

endmodule

// File: tb/tb_fixed_mem_reader.sv
// Bench for fixed_mem_reader with a small behavioural ROM on DQ.
module tb_fixed_mem_reader;

   localparam int AC = 5;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic        REQ;
   logic [16:0] ADDR;
   logic        BUSY, DONE, PAR_ERR, CE_, OE_, WE_;
   logic [15:0] DATA;
   logic [16:0] A;
   logic [15:0] DQ;

   typedef struct packed {
      logic [15:0] d;
      logic        p;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   done_total = 0;

   fixed_mem_reader #(.ACCESS_CYCLES(AC)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .REQ(REQ), .ADDR(ADDR),
      .BUSY(BUSY), .DONE(DONE), .DATA(DATA), .PAR_ERR(PAR_ERR),
      .CE_(CE_), .OE_(OE_), .WE_(WE_), .A(A), .DQ(DQ)
   );

   always #5 CLOCK = ~CLOCK;

   function automatic logic [15:0] rom(input logic [16:0] addr);
      case (addr)
         17'h00000: return 16'h8000;
         17'h00001: return 16'h0003;
         17'h00010: return 16'h0001;
         default:   return 16'hFFFF;
      endcase
   endfunction

   // ROM drives the bus only while selected and output-enabled; otherwise pulled down.
   assign DQ = (!CE_ && !OE_) ? rom(A) : 16'h0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   // Scoreboard consumer: every DONE pops one expected word.
   always @(negedge CLOCK) begin
      if (DONE) begin
         done_total++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_data", {16'h0, DATA}, {16'h0, e.d});
            chk("done_par", {31'h0, PAR_ERR}, {31'h0, e.p});
         end
      end
   end

   // One request; measures OE_/CE_ low cycles and the DONE position after acceptance.
   task automatic run_read(input logic [16:0] addr, input logic [15:0] d, input logic p);
      int oe_low = 0, ce_low = 0, done_idx = -1, done_cnt = 0;
      sb.push_back('{d: d, p: p});
      ADDR = addr;
      REQ  = 1'b1;
      tick();
      REQ = 1'b0;
      chk("acc_addr", {15'h0, A}, {15'h0, addr});
      chk("acc_busy", {31'h0, BUSY}, 32'd1);
      for (int i = 0; i < 14; i++) begin
         if (i > 0) tick();
         if (!OE_) oe_low++;
         if (!CE_) ce_low++;
         if (DONE) begin
            done_cnt++;
            if (done_idx < 0) done_idx = i;
         end
      end
      chk("oe_low_cycles", oe_low, AC);
      chk("ce_low_cycles", ce_low, AC + 1);
      chk("done_position", done_idx, AC + 1);
      chk("done_pulses", done_cnt, 1);
      chk("data_held", {16'h0, DATA}, {16'h0, d});
      chk("par_held", {31'h0, PAR_ERR}, {31'h0, p});
      chk("idle_busy", {31'h0, BUSY}, 32'd0);
   endtask

   initial begin
      int d0, gap, run, had_low, seen_idle, first_done, second_done, dcount;
      RESET = 1'b1;
      REQ   = 1'b0;
      ADDR  = 17'h0;
      tick(); tick(); tick();
      RESET = 1'b0;
      chk("rst_ce", {31'h0, CE_}, 32'd1);
      chk("rst_oe", {31'h0, OE_}, 32'd1);
      chk("rst_we", {31'h0, WE_}, 32'd1);
      chk("rst_a", {15'h0, A}, 32'd0);
      chk("rst_busy", {31'h0, BUSY}, 32'd0);
      chk("rst_done", {31'h0, DONE}, 32'd0);
      chk("rst_data", {16'h0, DATA}, 32'd0);
      chk("rst_par", {31'h0, PAR_ERR}, 32'd0);
      tick(); tick(); tick();
      chk("noreq_ce", {31'h0, CE_}, 32'd1);
      chk("noreq_busy", {31'h0, BUSY}, 32'd0);

      // Single read with odd-parity word
      run_read(17'h00010, 16'h0001, 1'b0);

      // Unprogrammed location, then address changes without REQ
      run_read(17'h1FFFF, 16'hFFFF, 1'b1);
      ADDR = 17'h1F000;
      tick(); tick(); tick();
      chk("a_held_idle", {15'h0, A}, 32'h1FFFF);

      // Back-to-back reads with REQ held high
      sb.push_back('{d: 16'h8000, p: 1'b0});
      sb.push_back('{d: 16'h0003, p: 1'b1});
      d0 = done_total;
      ADDR = 17'h00000;
      REQ  = 1'b1;
      tick();
      ADDR = 17'h00001;
      gap = -1; run = 0; had_low = 0; seen_idle = 0;
      first_done = -1; second_done = -1; dcount = 0;
      for (int i = 0; i < 30; i++) begin
         if (i > 0) tick();
         if (DONE) begin
            dcount++;
            if (first_done < 0) first_done = i;
            else if (second_done < 0) second_done = i;
         end
         if (CE_) begin
            if (had_low) run++;
         end else begin
            if (run > 0 && gap < 0) gap = run;
            had_low = 1;
            run = 0;
         end
         if (!BUSY) seen_idle = 1;
         else if (seen_idle) REQ = 1'b0;
      end
      REQ = 1'b0;
      chk("b2b_done_count", dcount, 2);
      chk("b2b_done_spacing", second_done - first_done, AC + 3);
      chk("b2b_ce_gap_min2", (gap >= 2) ? 1 : 0, 1);
      chk("b2b_addr", {15'h0, A}, 32'h00001);

      // REQ toggling while busy is ignored
      d0 = done_total;
      sb.push_back('{d: 16'h0001, p: 1'b0});
      ADDR = 17'h00010;
      REQ  = 1'b1;
      tick();
      ADDR = 17'h0ABCD;
      REQ  = 1'b0;
      for (int i = 0; i < 14; i++) begin
         REQ = BUSY ? ~REQ : 1'b0;
         tick();
      end
      REQ = 1'b0;
      tick(); tick();
      chk("ignore_addr", {15'h0, A}, 32'h00010);
      chk("ignore_one_done", done_total - d0, 1);

      // Reset during the third ACCESS cycle aborts the read
      d0 = done_total;
      ADDR = 17'h00010;
      REQ  = 1'b1;
      tick();                 // accepted, SETUP
      REQ = 1'b0;
      tick(); tick(); tick(); // third ACCESS cycle
      chk("abort_in_access", {31'h0, OE_}, 32'd0);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      chk("abort_ce", {31'h0, CE_}, 32'd1);
      chk("abort_oe", {31'h0, OE_}, 32'd1);
      chk("abort_busy", {31'h0, BUSY}, 32'd0);
      chk("abort_done", {31'h0, DONE}, 32'd0);
      chk("abort_data", {16'h0, DATA}, 32'd0);
      for (int i = 0; i < 10; i++) tick();
      chk("abort_no_done", done_total - d0, 0);

      // Fresh request after abort
      run_read(17'h00001, 16'h0003, 1'b1);
      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
